// File: rtl/gyro_axis_conditioner.sv
// Zero-rate calibration, offset correction, deadband and saturating integration for PmodGYRO x/y/z rates.
// Define GYRO_COND_DEADBAND_EN to enable the deadband stage; otherwise rate is the saturated corrected value.
module gyro_axis_conditioner #(
  parameter int CAL_SHIFT = 4,
  parameter int DEADBAND  = 16,
  parameter int ANGLE_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [15:0]         x_in,
  input  logic [15:0]         y_in,
  input  logic [15:0]         z_in,
  input  logic                recal,
  output logic                out_valid,
  output logic [15:0]         x_rate,
  output logic [15:0]         y_rate,
  output logic [15:0]         z_rate,
  output logic [ANGLE_W-1:0]  x_angle,
  output logic [ANGLE_W-1:0]  y_angle,
  output logic [ANGLE_W-1:0]  z_angle,
  output logic                calibrated
);

  localparam int SUM_W = 16 + CAL_SHIFT;
  localparam logic [CAL_SHIFT-1:0] LAST_COUNT = '1;

  typedef enum logic {CAL, RUN} state_t;

  state_t              state;
  logic [CAL_SHIFT-1:0] count;

  logic [15:0]        sample    [3];
  logic [15:0]        offset    [3];
  logic [15:0]        rate_q    [3];
  logic [15:0]        rate_nxt  [3];
  logic [15:0]        sat       [3];
  logic [15:0]        cal_off   [3];
  logic [16:0]        diff      [3];
  logic [SUM_W-1:0]   sum       [3];
  logic [SUM_W-1:0]   sum_nxt   [3];
  logic [SUM_W-1:0]   avg       [3];
  logic [ANGLE_W-1:0] angle_q   [3];
  logic [ANGLE_W-1:0] angle_nxt [3];
  logic [ANGLE_W:0]   angle_sum [3];
`ifdef GYRO_COND_DEADBAND_EN
  logic [16:0]        mag       [3];
`endif

  assign sample[0] = x_in;
  assign sample[1] = y_in;
  assign sample[2] = z_in;

  // Corrected rate is clamped to 16 bits before deadband; the angle adds one guard bit to detect overflow.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      diff[i] = {sample[i][15], sample[i]} - {offset[i][15], offset[i]};
      case (diff[i][16:15])
        2'b01:   sat[i] = 16'h7FFF;
        2'b10:   sat[i] = 16'h8000;
        default: sat[i] = diff[i][15:0];
      endcase
`ifdef GYRO_COND_DEADBAND_EN
      mag[i] = sat[i][15] ? (17'd0 - {sat[i][15], sat[i]}) : {1'b0, sat[i]};
      rate_nxt[i] = (mag[i] <= 17'(DEADBAND)) ? 16'h0000 : sat[i];
`else
      rate_nxt[i] = sat[i];
`endif
      angle_sum[i] = {angle_q[i][ANGLE_W-1], angle_q[i]}
                   + {{(ANGLE_W-15){rate_nxt[i][15]}}, rate_nxt[i]};
      case (angle_sum[i][ANGLE_W:ANGLE_W-1])
        2'b01:   angle_nxt[i] = {1'b0, {(ANGLE_W-1){1'b1}}};
        2'b10:   angle_nxt[i] = {1'b1, {(ANGLE_W-1){1'b0}}};
        default: angle_nxt[i] = angle_sum[i][ANGLE_W-1:0];
      endcase
      sum_nxt[i] = sum[i] + {{CAL_SHIFT{sample[i][15]}}, sample[i]};
      avg[i]     = SUM_W'($signed(sum_nxt[i]) >>> CAL_SHIFT);
      cal_off[i] = avg[i][15:0];
    end
  end

  // Offsets survive recal so the old correction stays in place until the new average is known.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CAL;
      count      <= '0;
      out_valid  <= 1'b0;
      calibrated <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sum[i]     <= '0;
        offset[i]  <= '0;
        rate_q[i]  <= '0;
        angle_q[i] <= '0;
      end
    end else if (recal) begin
      state      <= CAL;
      count      <= '0;
      out_valid  <= 1'b0;
      calibrated <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sum[i]     <= '0;
        rate_q[i]  <= '0;
        angle_q[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        CAL: begin
          if (in_valid) begin
            count <= count + 1'b1;
            if (count == LAST_COUNT) begin
              state      <= RUN;
              calibrated <= 1'b1;
              for (int i = 0; i < 3; i++) begin
                offset[i] <= cal_off[i];
                sum[i]    <= '0;
              end
            end else begin
              for (int i = 0; i < 3; i++) sum[i] <= sum_nxt[i];
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            for (int i = 0; i < 3; i++) begin
              rate_q[i]  <= rate_nxt[i];
              angle_q[i] <= angle_nxt[i];
            end
          end
        end
        default: state <= CAL;
      endcase
    end
  end

  assign x_rate  = rate_q[0];
  assign y_rate  = rate_q[1];
  assign z_rate  = rate_q[2];
  assign x_angle = angle_q[0];
  assign y_angle = angle_q[1];
  assign z_angle = angle_q[2];

endmodule

// File: tb/tb_gyro_axis_conditioner.sv
// Self-checking bench for gyro_axis_conditioner: directed scenarios plus randomized traffic against an integer model.
module tb_gyro_axis_conditioner;

  localparam int CS   = 2;
  localparam int DB   = 16;
  localparam int AW   = 18;
  localparam int NCAL = 1 << CS;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));
`ifdef GYRO_COND_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          recal = 1'b0;
  logic [15:0]   x_in = '0, y_in = '0, z_in = '0;
  logic          out_valid, calibrated;
  logic [15:0]   x_rate, y_rate, z_rate;
  logic [AW-1:0] x_angle, y_angle, z_angle;

  gyro_axis_conditioner #(.CAL_SHIFT(CS), .DEADBAND(DB), .ANGLE_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .recal(recal),
    .out_valid(out_valid),
    .x_rate(x_rate), .y_rate(y_rate), .z_rate(z_rate),
    .x_angle(x_angle), .y_angle(y_angle), .z_angle(z_angle),
    .calibrated(calibrated)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed as plain integers
  bit m_cal, m_ov;
  int m_cnt;
  int m_sum [3];
  int m_off [3];
  int m_rate[3];
  int m_ang [3];

  function automatic int got_rate(int i);
    case (i)
      0: return int'($signed(x_rate));
      1: return int'($signed(y_rate));
      default: return int'($signed(z_rate));
    endcase
  endfunction

  function automatic int got_ang(int i);
    case (i)
      0: return int'($signed(x_angle));
      1: return int'($signed(y_angle));
      default: return int'($signed(z_angle));
    endcase
  endfunction

  // Applies one cycle of inputs, advances the model, and returns 1 time unit after the edge
  task automatic drive(input bit r, input bit rc, input bit v, input int x, input int y, input int z);
    int s[3];
    int d;
    rst = r; recal = rc; in_valid = v;
    x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
    s[0] = int'($signed(x_in)); s[1] = int'($signed(y_in)); s[2] = int'($signed(z_in));
    if (r || rc) begin
      m_cal = 0; m_ov = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
        m_sum[i] = 0; m_rate[i] = 0; m_ang[i] = 0;
        if (r) m_off[i] = 0;
      end
    end else begin
      m_ov = 0;
      if (v && !m_cal) begin
        m_cnt++;
        for (int i = 0; i < 3; i++) m_sum[i] += s[i];
        if (m_cnt == NCAL) begin
          for (int i = 0; i < 3; i++) begin
            m_off[i] = m_sum[i] >>> CS;
            m_sum[i] = 0;
          end
          m_cnt = 0;
          m_cal = 1;
        end
      end else if (v) begin
        m_ov = 1;
        for (int i = 0; i < 3; i++) begin
          d = s[i] - m_off[i];
          if (d > 32767) d = 32767;
          if (d < -32768) d = -32768;
          if (DB_EN && d >= -DB && d <= DB) d = 0;
          m_rate[i] = d;
          m_ang[i] = m_ang[i] + d;
          if (m_ang[i] > AMAX) m_ang[i] = AMAX;
          if (m_ang[i] < AMIN) m_ang[i] = AMIN;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1234, -5, 9);
    n_checks++;
    if (out_valid !== 1'b0 || calibrated !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got ov=%0b cal=%0b need 0 0", out_valid, calibrated);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_rate(i) !== 0 || got_ang(i) !== 0) begin
        n_fail++;
        $display("[TB] FAIL reset_axis%0d got rate=%0d angle=%0d need 0 0", i, got_rate(i), got_ang(i));
      end
    end
  endtask

  task automatic test_calibration();
    int xs[4] = '{100, 102, 98, 100};
    int ys[4] = '{-101, -100, -100, -100};
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, xs[k], ys[k], ys[k]);
      n_checks++;
      if (calibrated !== (k == 3) || out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL cal_step%0d got cal=%0b ov=%0b need cal=%0b ov=0", k, calibrated, out_valid, k == 3);
      end
    end
  endtask

  task automatic test_integration();
    int exp_x[3] = '{50, 100, 150};
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 150, -51, -101);
      n_checks++;
      if (out_valid !== 1'b1 || got_rate(0) !== 50 || got_ang(0) !== exp_x[k] || got_rate(1) !== 50) begin
        n_fail++;
        $display("[TB] FAIL integ_step%0d got ov=%0b xr=%0d xa=%0d yr=%0d need 1 50 %0d 50",
                 k, out_valid, got_rate(0), got_ang(0), got_rate(1), exp_x[k]);
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_rate(i) !== m_rate[i] || got_ang(i) !== m_ang[i]) begin
          n_fail++;
          $display("[TB] FAIL integ_model axis%0d got %0d/%0d need %0d/%0d", i, got_rate(i), got_ang(i), m_rate[i], m_ang[i]);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b0 || got_ang(0) !== 150 || got_rate(0) !== 50) begin
      n_fail++;
      $display("[TB] FAIL integ_hold got ov=%0b xa=%0d xr=%0d need 0 150 50", out_valid, got_ang(0), got_rate(0));
    end
  endtask

  task automatic test_deadband();
    int exp_r;
    exp_r = DB_EN ? 0 : 10;
    drive(0, 0, 1, 110, -101, -101);
    n_checks++;
    if (out_valid !== 1'b1 || got_rate(0) !== exp_r || got_ang(0) !== 150 + exp_r) begin
      n_fail++;
      $display("[TB] FAIL deadband got ov=%0b xr=%0d xa=%0d need 1 %0d %0d", out_valid, got_rate(0), got_ang(0), exp_r, 150 + exp_r);
    end
    drive(0, 0, 1, 100 + DB + 1, -101 - DB - 1, -101);
    n_checks++;
    if (got_rate(0) !== DB + 1 || got_rate(1) !== -DB - 1) begin
      n_fail++;
      $display("[TB] FAIL deadband_edge got xr=%0d yr=%0d need %0d %0d", got_rate(0), got_rate(1), DB + 1, -DB - 1);
    end
  endtask

  task automatic test_saturation();
    int exp_a[5] = '{32767, 65534, 98301, 131068, 131071};
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, -100, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 32767, -32768, 0);
      n_checks++;
      if (got_rate(0) !== 32767 || got_ang(0) !== exp_a[k]) begin
        n_fail++;
        $display("[TB] FAIL sat_step%0d got xr=%0d xa=%0d need 32767 %0d", k, got_rate(0), got_ang(0), exp_a[k]);
      end
      n_checks++;
      if (got_ang(1) !== m_ang[1] || got_rate(2) !== m_rate[2] || got_ang(2) !== 0) begin
        n_fail++;
        $display("[TB] FAIL sat_other_axes got ya=%0d zr=%0d za=%0d need %0d %0d 0", got_ang(1), got_rate(2), got_ang(2), m_ang[1], m_rate[2]);
      end
    end
  endtask

  task automatic test_recal();
    drive(0, 1, 1, 500, 500, 500);
    n_checks++;
    if (calibrated !== 1'b0 || out_valid !== 1'b0 || got_ang(0) !== 0 || got_rate(0) !== 0 || got_ang(1) !== 0) begin
      n_fail++;
      $display("[TB] FAIL recal_clear got cal=%0b ov=%0b xa=%0d xr=%0d ya=%0d need all 0",
               calibrated, out_valid, got_ang(0), got_rate(0), got_ang(1));
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 200, 0, 0);
      n_checks++;
      if (calibrated !== (k == 3) || out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL recal_step%0d got cal=%0b ov=%0b need cal=%0b ov=0", k, calibrated, out_valid, k == 3);
      end
    end
    drive(0, 0, 1, 260, 0, 0);
    n_checks++;
    if (got_rate(0) !== 60 || got_ang(0) !== 60) begin
      n_fail++;
      $display("[TB] FAIL recal_offset got xr=%0d xa=%0d need 60 60", got_rate(0), got_ang(0));
    end
  endtask

  task automatic test_reset_midcal();
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 7, 7, 7);
    drive(0, 0, 1, 7, 7, 7);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 40, 0, 0);
      n_checks++;
      if (calibrated !== (k == 3)) begin
        n_fail++;
        $display("[TB] FAIL midcal_step%0d got cal=%0b need %0b", k, calibrated, k == 3);
      end
    end
    drive(0, 0, 1, 140, 0, 0);
    n_checks++;
    if (got_rate(0) !== 100 || out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midcal_offset got xr=%0d ov=%0b need 100 1", got_rate(0), out_valid);
    end
  endtask

  task automatic test_random();
    int base[3];
    int s[3];
    logic [15:0] r16;
    bit v, rc;
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) base[i] = int'($urandom_range(0, 4000)) - 2000;
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          r16 = 16'($urandom);
          s[i] = int'($signed(r16));
        end else begin
          s[i] = base[i] + int'($urandom_range(0, 80)) - 40;
        end
      end
      drive(0, rc, v, s[0], s[1], s[2]);
      n_checks++;
      if (out_valid !== m_ov || calibrated !== m_cal) begin
        n_fail++;
        $display("[TB] FAIL rand_flags c=%0d got ov=%0b cal=%0b need %0b %0b", c, out_valid, calibrated, m_ov, m_cal);
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_rate(i) !== m_rate[i] || got_ang(i) !== m_ang[i]) begin
          n_fail++;
          $display("[TB] FAIL rand_axis%0d c=%0d got %0d/%0d need %0d/%0d", i, c, got_rate(i), got_ang(i), m_rate[i], m_ang[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_integration();
    test_deadband();
    test_saturation();
    test_recal();
    test_reset_midcal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
